// File: rtl/tage_tbl_pkg.sv
// Package for the TAGE tagged-table controller.
// Holds table geometry, entry field offsets, the buffered update request
// type, the controller state encoding and a small saturating-counter helper.
package tage_tbl_pkg;

    localparam int IDX_W      = 9;
    localparam int ENTRY_W    = 12;
    localparam int UPD_DEPTH  = 2;
    localparam int STARVE_MAX = 3;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    // Entry layout {tag[11:5], ctr[4:2], u[1:0]}
    localparam int TAG_LSB = 5;
    localparam int CTR_LSB = 2;
    localparam int U_LSB   = 0;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [ENTRY_W-1:0] data;
        logic [ENTRY_W-1:0] mask;
    } upd_req_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tbl_state_e;

    // Saturating increment of the starvation counter
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        logic [STARVE_W-1:0] res;
        if (cnt == STARVE_W'(STARVE_MAX)) begin
            res = cnt;
        end else begin
            res = cnt + STARVE_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/tage_upd_fifo.sv
// Synchronous FIFO of buffered training updates (UPD_DEPTH entries).
// Ports:
//   clock_i, reset_n_i : clock and asynchronous active-low reset
//   push_i, push_data_i: enqueue request (ignored when full)
//   pop_i              : dequeue request (ignored when empty)
//   head_o             : oldest entry, valid while empty_o is low
//   full_o, empty_o    : occupancy flags
module tage_upd_fifo
    import tage_tbl_pkg::*;
(
    input  logic     clock_i,
    input  logic     reset_n_i,
    input  logic     push_i,
    input  upd_req_t push_data_i,
    input  logic     pop_i,
    output upd_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(UPD_DEPTH);

    upd_req_t         mem_q [UPD_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic             push_s;
    logic             pop_s;

    // Wrap bit differs with equal low bits means every slot is occupied
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer next-state
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '{idx: {IDX_W{1'b0}}, data: {ENTRY_W{1'b0}}, mask: {ENTRY_W{1'b0}}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/tage_tagged_table_ctrl.sv
// Requester-side controller for one 512x12 single-port TAGE tagged-table SRAM.
// Arbitrates predictor lookups (reads) against buffered training updates
// (masked writes) on the single RW port; read data returns one cycle after issue.
// Optional macro TAGE_TBL_INIT_EN: clear all entries (wdata=0, wmask=all ones)
// right after reset before accepting traffic.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   lkp_valid/lkp_ready/lkp_idx    : lookup request handshake
//   rsp_valid/rsp_data             : lookup response, no backpressure
//   upd_valid/upd_ready/upd_idx/
//   upd_data/upd_mask              : training update handshake
//   init_done                      : table ready for traffic
//   ram_addr/en/wmode/wdata/wmask  : to SRAM RW0 port
//   ram_rdata                      : from SRAM RW0 port, valid cycle after read
module tage_tagged_table_ctrl
    import tage_tbl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               lkp_valid,
    output logic               lkp_ready,
    input  logic [IDX_W-1:0]   lkp_idx,
    output logic               rsp_valid,
    output logic [ENTRY_W-1:0] rsp_data,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic [ENTRY_W-1:0] upd_data,
    input  logic [ENTRY_W-1:0] upd_mask,
    output logic               init_done,
    output logic [IDX_W-1:0]   ram_addr,
    output logic               ram_en,
    output logic               ram_wmode,
    output logic [ENTRY_W-1:0] ram_wdata,
    output logic [ENTRY_W-1:0] ram_wmask,
    input  logic [ENTRY_W-1:0] ram_rdata
);

    tbl_state_e          state_q;
    tbl_state_e          state_d;
    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                rd_pend_q;
    logic [ENTRY_W-1:0]  rsp_hold_q;
    logic [ENTRY_W-1:0]  rsp_hold_d;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    logic                rd_issue_s;
    logic                force_upd_s;
    upd_req_t            head_s;
    upd_req_t            push_req_s;

`ifdef TAGE_TBL_INIT_EN
    logic [IDX_W-1:0]    init_cnt_q;
    logic [IDX_W-1:0]    init_cnt_d;
    logic                init_last_s;

    assign init_last_s = (init_cnt_q == {IDX_W{1'b1}});

    // Init address counter: one clear write per INIT cycle
    always_comb begin
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_W'(1);
        end else begin
            init_cnt_d = init_cnt_q;
        end
    end

    // Init counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt_q <= {IDX_W{1'b0}};
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    assign push_req_s = '{idx: upd_idx, data: upd_data, mask: upd_mask};
    assign push_s     = upd_valid & upd_ready;

    tage_upd_fifo u_upd_fifo (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .push_i      (push_s),
        .push_data_i (push_req_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // An update is forced once the FIFO is full or it has lost STARVE_MAX times
    assign force_upd_s = ~fifo_empty_s &
                         (fifo_full_s | (starve_cnt_q == STARVE_W'(STARVE_MAX)));

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef TAGE_TBL_INIT_EN
            state_q <= ST_INIT;
`else
            state_q <= ST_RUN;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: INIT leaves after the last entry is cleared, RUN is terminal
    always_comb begin
        case (state_q)
            ST_INIT: begin
`ifdef TAGE_TBL_INIT_EN
                if (init_last_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs and port arbitration: lookup first, then FIFO head
    always_comb begin
        lkp_ready  = 1'b0;
        upd_ready  = 1'b0;
        init_done  = 1'b0;
        ram_en     = 1'b0;
        ram_wmode  = 1'b0;
        ram_addr   = {IDX_W{1'b0}};
        ram_wdata  = {ENTRY_W{1'b0}};
        ram_wmask  = {ENTRY_W{1'b0}};
        pop_s      = 1'b0;
        rd_issue_s = 1'b0;
        case (state_q)
            ST_INIT: begin
`ifdef TAGE_TBL_INIT_EN
                // Gated by reset_n so the SRAM sees no enable while held in reset
                ram_en    = reset_n;
                ram_wmode = 1'b1;
                ram_addr  = init_cnt_q;
                ram_wmask = {ENTRY_W{1'b1}};
`else
                ram_en    = 1'b0;
`endif
            end
            ST_RUN: begin
                init_done = 1'b1;
                upd_ready = ~fifo_full_s;
                lkp_ready = ~force_upd_s;
                if (lkp_valid && !force_upd_s) begin
                    ram_en     = 1'b1;
                    ram_addr   = lkp_idx;
                    rd_issue_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    ram_en    = 1'b1;
                    ram_wmode = 1'b1;
                    ram_addr  = head_s.idx;
                    ram_wdata = head_s.data;
                    ram_wmask = head_s.mask;
                    pop_s     = 1'b1;
                end else begin
                    ram_en = 1'b0;
                end
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts lookups that beat a pending update
    always_comb begin
        if (fifo_empty_s || pop_s) begin
            starve_cnt_d = {STARVE_W{1'b0}};
        end else if (rd_issue_s) begin
            starve_cnt_d = starve_inc(starve_cnt_q);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Response path: SRAM data is passed through in the response cycle and held afterwards
    always_comb begin
        if (rd_pend_q) begin
            rsp_hold_d = ram_rdata;
            rsp_data   = ram_rdata;
        end else begin
            rsp_hold_d = rsp_hold_q;
            rsp_data   = rsp_hold_q;
        end
    end

    assign rsp_valid = rd_pend_q;

    // Response and starvation registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q    <= 1'b0;
            rsp_hold_q   <= {ENTRY_W{1'b0}};
            starve_cnt_q <= {STARVE_W{1'b0}};
        end else begin
            rd_pend_q    <= rd_issue_s;
            rsp_hold_q   <= rsp_hold_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
